// File: rtl/spi_target_regs.sv
// spi_target_regs: SPI mode-0 target exposing an 8x8-bit register file.
// SCK/MOSI/nSS are oversampled in the clk domain. A frame is one command
// byte followed by auto-incrementing data bytes. Local logic gets a
// combinational read port and a write port, and each SPI-written byte is
// reported with a one-cycle strobe.
module spi_target_regs #(
    parameter int NREGS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       nss,
    output logic       miso,
    output logic       miso_oe,
    input  logic [2:0] laddr,
    output logic [7:0] lrdata,
    input  logic       lwe,
    input  logic [7:0] lwdata,
    output logic       wstb,
    output logic [2:0] waddr,
    output logic [7:0] wdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } state_t;

    logic       sck_s1, sck_s2, sck_s3;
    logic       mosi_s1, mosi_s2;
    logic       nss_s1, nss_s2;
    logic       armed;
    logic       selected;
    logic       sck_rise, sck_fall;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] rx_next;
    logic [7:0] tx_sr;
    logic [2:0] addr;
    logic [7:0] regs [NREGS];

    // Synchronize the SPI pins. The nss chain resets to "low" and stays
    // ignored until armed, which needs a real high from the pin. A frame
    // that is already running when reset is released is therefore ignored
    // until nSS deasserts and asserts again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            nss_s1  <= 1'b0;
            nss_s2  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous stage's old value, forming a real shift chain.
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            nss_s1  <= nss;
            nss_s2  <= nss_s1;
            armed   <= armed | nss_s2;
        end
    end

    assign selected = armed & ~nss_s2;
    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;
    assign rx_next  = {rx_sr[6:0], mosi_s2};

    assign busy    = selected;
    assign miso_oe = selected;
    assign lrdata  = regs[laddr];

    // Frame FSM, TX/RX shifting and the register file share one block, so
    // SPI writes and read snapshots use the same edge as the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            rx_sr   <= 8'h00;
            tx_sr   <= 8'h00;
            addr    <= 3'd0;
            miso    <= 1'b0;
            wstb    <= 1'b0;
            waddr   <= 3'd0;
            wdata   <= 8'h00;
            // NOTE: the register file is small and must read as zero after reset, so it is cleared here rather than left as uninitialized RAM.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            wstb <= 1'b0;
            if (lwe) begin
                regs[laddr] <= lwdata;
            end
            if (!selected) begin
                // Deselection wins over everything, including an eighth SCK rise in the same cycle.
                state   <= IDLE;
                bit_cnt <= 3'd0;
                rx_sr   <= 8'h00;
                miso    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        bit_cnt <= 3'd0;
                        rx_sr   <= 8'h00;
                        miso    <= 1'b0;
                    end
                    CMD: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (rx_next[7]) begin
                                    state <= RD;
                                    tx_sr <= regs[rx_next[2:0]];
                                    miso  <= regs[rx_next[2:0]][7];
                                    addr  <= rx_next[2:0] + 3'd1;
                                end else begin
                                    state <= WR;
                                    addr  <= rx_next[2:0];
                                end
                            end
                        end
                    end
                    WR: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                // NOTE: this assignment comes after the local write above, so on an address clash the SPI write is the one that lands.
                                regs[addr] <= rx_next;
                                wstb       <= 1'b1;
                                waddr      <= addr;
                                wdata      <= rx_next;
                                addr       <= addr + 3'd1;
                            end
                        end
                    end
                    RD: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                tx_sr <= regs[addr];
                                miso  <= regs[addr][7];
                                addr  <= addr + 3'd1;
                            end
                        end else if (sck_fall && bit_cnt != 3'd0) begin
                            // The fall that follows a byte boundary keeps the freshly loaded bit 7 on MISO.
                            tx_sr <= {tx_sr[6:0], 1'b0};
                            miso  <= tx_sr[6];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_target_regs.sv
// Testbench for spi_target_regs: directed SPI frames driven by a bit-banged
// master. Expected write strobes and expected read bytes are queued as
// stimulus is issued, and a monitor pops and compares them as they appear.
module tb_spi_target_regs;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck, mosi, nss;
    logic       miso, miso_oe;
    logic [2:0] laddr;
    logic [7:0] lrdata;
    logic       lwe;
    logic [7:0] lwdata;
    logic       wstb;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  got_rd[$];
    logic [7:0]  frame[$];

    spi_target_regs #(.NREGS(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .sck    (sck),
        .mosi   (mosi),
        .nss    (nss),
        .miso   (miso),
        .miso_oe(miso_oe),
        .laddr  (laddr),
        .lrdata (lrdata),
        .lwe    (lwe),
        .lwdata (lwdata),
        .wstb   (wstb),
        .waddr  (waddr),
        .wdata  (wdata),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write strobe and every captured read byte.
    initial begin
        logic [10:0] e;
        logic [7:0]  g;
        forever begin
            @(negedge clk);
            if (wstb) begin
                if (exp_wr.size() == 0) begin
                    check("wstb_unexpected", {31'd0, wstb}, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wstb_addr", {29'd0, waddr}, {29'd0, e[10:8]});
                    check("wstb_data", {24'd0, wdata}, {24'd0, e[7:0]});
                end
            end
            while (got_rd.size() > 0) begin
                g = got_rd.pop_front();
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got 0x%0h expected none", g);
                end else begin
                    check("miso_byte", {24'd0, g}, {24'd0, exp_rd.pop_front()});
                end
            end
        end
    end

    // Master shifts nbits of tx MSB first, sampling MISO at each rise.
    // With collide set, LWE is pulsed so it lands on the DUT's write edge
    // for this byte's eighth rise.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit collide,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            rx  = {rx[6:0], miso};
            if (collide && i == 0) begin
                repeat (2) @(negedge clk);
                lwe = 1'b1;
                @(negedge clk);
                lwe = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input bit capture, input int collide_byte);
        logic [7:0] rx;
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
        check("busy_selected", {31'd0, busy}, 32'd1);
        check("miso_oe_selected", {31'd0, miso_oe}, 32'd1);
        for (int i = 0; i < frame.size(); i++) begin
            spi_byte(frame[i], 8, (i == collide_byte), rx);
            if (capture) got_rd.push_back(rx);
        end
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (HALF) @(negedge clk);
        check("busy_deselected", {31'd0, busy}, 32'd0);
        check("miso_oe_deselected", {31'd0, miso_oe}, 32'd0);
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [7:0] v);
        laddr = a;
        @(negedge clk);
        check(name, {24'd0, lrdata}, {24'd0, v});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        rst = 1'b1; sck = 1'b0; mosi = 1'b0; nss = 1'b1;
        laddr = 3'd0; lwe = 1'b0; lwdata = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_wstb", {31'd0, wstb}, 32'd0);
        check("rst_waddr", {29'd0, waddr}, 32'd0);
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 8; a++) check_reg("rst_reg", 3'(a), 8'h00);
        repeat (HALF) @(negedge clk);

        // Write burst from address 5.
        exp_wr.push_back({3'd5, 8'hAA});
        exp_wr.push_back({3'd6, 8'hBB});
        exp_wr.push_back({3'd7, 8'hCC});
        frame = '{8'h05, 8'hAA, 8'hBB, 8'hCC};
        spi_frame(0, -1);
        check_reg("burst_reg5", 3'd5, 8'hAA);
        check_reg("burst_reg6", 3'd6, 8'hBB);
        check_reg("burst_reg7", 3'd7, 8'hCC);

        // Read from 6 with wrap 7 -> 0; command byte must read as zero.
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'hBB);
        exp_rd.push_back(8'hCC);
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h00);
        frame = '{8'h86, 8'h00, 8'h00, 8'h00, 8'h00};
        spi_frame(1, -1);

        // Abort: command then five bits of 0xFF, then deselect.
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'h02, 8, 0, rx);
        spi_byte(8'hFF, 5, 0, rx);
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (HALF) @(negedge clk);
        check_reg("abort_reg2", 3'd2, 8'h00);
        exp_wr.push_back({3'd2, 8'h11});
        frame = '{8'h02, 8'h11};
        spi_frame(0, -1);
        check_reg("after_abort_reg2", 3'd2, 8'h11);

        // Collision on the same address: SPI wins.
        laddr = 3'd3; lwdata = 8'h55;
        exp_wr.push_back({3'd3, 8'h99});
        frame = '{8'h03, 8'h99};
        spi_frame(0, 1);
        check_reg("collide_same_reg3", 3'd3, 8'h99);
        // Collision on different addresses: both land.
        laddr = 3'd4; lwdata = 8'h55;
        exp_wr.push_back({3'd3, 8'h99});
        frame = '{8'h03, 8'h99};
        spi_frame(0, 1);
        check_reg("collide_diff_reg4", 3'd4, 8'h55);
        check_reg("collide_diff_reg3", 3'd3, 8'h99);

        // Snapshot: local write during the data byte does not alter it.
        laddr = 3'd1; lwdata = 8'h3C; lwe = 1'b1;
        @(negedge clk);
        lwe = 1'b0;
        check_reg("snap_pre_reg1", 3'd1, 8'h3C);
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h3C);
        frame = '{8'h81, 8'h00};
        fork
            spi_frame(1, -1);
            begin
                repeat (HALF * 19) @(negedge clk);
                laddr = 3'd1; lwdata = 8'hFF; lwe = 1'b1;
                @(negedge clk);
                lwe = 1'b0;
            end
        join
        check_reg("snap_post_reg1", 3'd1, 8'hFF);
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'hFF);
        frame = '{8'h81, 8'h00};
        spi_frame(1, -1);

        // Reset during the second data byte of a write frame.
        exp_wr.push_back({3'd4, 8'h77});
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'h04, 8, 0, rx);
        spi_byte(8'h77, 8, 0, rx);
        spi_byte(8'h66, 3, 0, rx);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check_reg("midrst_reg4", 3'd4, 8'h00);
        check_reg("midrst_reg1", 3'd1, 8'h00);
        rst = 1'b0;
        spi_byte(8'hFF, 5, 0, rx);
        spi_byte(8'h55, 8, 0, rx);
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (HALF) @(negedge clk);
        check_reg("midrst_after_reg4", 3'd4, 8'h00);
        exp_wr.push_back({3'd4, 8'h12});
        frame = '{8'h04, 8'h12};
        spi_frame(0, -1);
        check_reg("newframe_reg4", 3'd4, 8'h12);
        check_reg("newframe_reg5", 3'd5, 8'h00);

        repeat (20) @(negedge clk);
        check("wr_queue_drained", exp_wr.size(), 32'd0);
        check("rd_queue_drained", exp_rd.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
